// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants,
// also used by the transmitter.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_SAMPLE_MID = 7;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs; RESET_VAL sets the
// value both flops take during reset (1 for an idle-high serial line).
module uart_sync2 #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, mid-bit sampling and a valid/ready output.
// Define UART_RX_PARITY_EN to expect and check one parity bit before the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy,
  output uart_rx_state_t       state_dbg
);

  localparam int                BCW       = $clog2(DATA_BITS);
  localparam logic [3:0]        TICK_LAST = 4'(UART_OVERSAMPLE - 1);
  localparam logic [3:0]        TICK_MID  = 4'(UART_SAMPLE_MID);
  localparam logic [BCW-1:0]    BIT_LAST  = BCW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_t    AFTER_DATA = RX_PARITY;
`else
  localparam uart_rx_state_t    AFTER_DATA = RX_STOP;
`endif

  uart_rx_state_t       state, state_next;
  logic                 rx_s;
  logic [3:0]           tick_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_tick, mid_tick;
  logic                 clr_tick, clr_bits, sample_data, finish;
  logic                 par_bad;
`ifdef UART_RX_PARITY_EN
  logic                 sample_par;
  logic                 par_bad_q;
`endif

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign bit_tick  = rx_tick && (tick_cnt == TICK_LAST);
  assign mid_tick  = rx_tick && (tick_cnt == TICK_MID);
  assign busy      = (state != RX_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    clr_tick    = 1'b0;
    clr_bits    = 1'b0;
    sample_data = 1'b0;
    finish      = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_par  = 1'b0;
`endif
    case (state)
      RX_IDLE: begin
        if (rx_tick && !rx_s) begin
          state_next = RX_START;
          clr_tick   = 1'b1;
        end
      end
      RX_START: begin
        // A start bit that is high again at its midpoint was a glitch.
        if (mid_tick) begin
          clr_tick   = 1'b1;
          clr_bits   = 1'b1;
          state_next = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_tick) begin
          sample_data = 1'b1;
          if (bit_cnt == BIT_LAST) state_next = AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (bit_tick) begin
          sample_par = 1'b1;
          state_next = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (bit_tick) begin
          finish     = 1'b1;
          state_next = RX_IDLE;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  // Tick counter wraps 15->0 by itself, so consecutive bits need no explicit clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      if (clr_tick)     tick_cnt <= '0;
      else if (rx_tick) tick_cnt <= tick_cnt + 4'd1;
      if (clr_bits)         bit_cnt <= '0;
      else if (sample_data) bit_cnt <= bit_cnt + 1'b1;
      if (sample_data) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          par_bad_q <= 1'b0;
    else if (clr_bits)   par_bad_q <= 1'b0;
    else if (sample_par) par_bad_q <= (^shreg) ^ rx_s ^ PARITY_ODD;
  end
  assign par_bad = par_bad_q;
`else
  // Parity sense has no effect without a parity bit in the frame.
  assign par_bad = PARITY_ODD & 1'b0;
`endif

  // Handshake: a word transfers on any cycle with rx_valid && rx_ready; rx_valid
  // drops next cycle unless a new word completes on that same edge, in which case
  // it stays high. Completion without rx_ready overwrites the word and flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= finish && rx_valid && !rx_ready;
      if (finish) begin
        rx_data    <= shreg;
        frame_err  <= !rx_s;
        parity_err <= par_bad;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames and
// glitches, scored against a queue of expected words built from the frame contents.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DB       = 8;
  localparam int W        = DB + 2;
  localparam bit P_ODD    = 1'b0;
  localparam int TICK_DIV = 3;

  logic          clk, rst_n, rx_tick, rx, rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, parity_err, overrun_err, busy;
  uart_rx_state_t state_dbg;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int ready_mode = 0;
  int valid_run = 0, last_valid_run = 0, valid_rises = 0, ovr_cycles = 0;
  logic prev_hs = 1'b0, prev_valid = 1'b0;

  uart_rx #(.DATA_BITS(DB), .PARITY_ODD(P_ODD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_tick     (rx_tick),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // Clock, tick and ready generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rx_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 rx_tick = 1'b1;
      @(posedge clk);
      #1 rx_tick = 1'b0;
    end
  end

  initial begin
    rx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = 1'b1;
        default: rx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected {parity_err, frame_err, data} from the frame as sent.
  function automatic logic [W-1:0] expect_word(input logic [DB-1:0] data, input logic stop,
                                               input logic par);
    logic pe;
    pe = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe = 1'(($countones(data) + int'(par) + int'(P_ODD)) % 2);
`else
    if (par) pe = 1'b0;
`endif
    return {pe, !stop, data};
  endfunction

  // Driver tasks: line changes 1 time unit after a clock edge, bits last 16 ticks.
  task automatic hold_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!rx_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    hold_ticks(UART_OVERSAMPLE);
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic stop, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
    rx = 1'b1;
  endtask

  function automatic logic good_par(input logic [DB-1:0] data);
    return 1'(($countones(data) + int'(P_ODD)) % 2);
  endfunction

  // Scoreboard / monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        valid_run  = 0;
        prev_hs    = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (rx_valid) valid_run++;
        else if (valid_run != 0) begin
          last_valid_run = valid_run;
          valid_run = 0;
        end
        if (rx_valid && !prev_valid) valid_rises++;
        if (overrun_err) ovr_cycles++;
        if (prev_hs) check("valid_clear", 32'(rx_valid), 32'd0);
        prev_hs = rx_valid && rx_ready;
        if (prev_hs) begin
          if (exp_q.size() == 0) check("word_expected", 32'(exp_q.size()), 32'd1);
          else check("word", 32'({parity_err, frame_err, rx_data}), 32'(exp_q.pop_front()));
        end
        prev_valid = rx_valid;
      end
    end
  end

  initial begin
    int rises0, ovr0;
    logic [DB-1:0] d;
    logic s, p;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_flags", 32'({frame_err, parity_err, overrun_err}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(RX_IDLE));
    rst_n = 1'b1;
    hold_ticks(4);

    // 0xA5 with ready held high
    ready_mode = 1;
    hold_ticks(2);
    exp_q.push_back(expect_word(8'hA5, 1'b1, good_par(8'hA5)));
    send_frame(8'hA5, 1'b1, good_par(8'hA5));
    hold_ticks(4);
    check("a5_drained", 32'(exp_q.size()), 32'd0);
    check("a5_valid_len", 32'(last_valid_run), 32'd1);
    check("a5_idle", 32'(busy), 32'd0);

    // Short low glitch on idle line
    rises0 = valid_rises;
    rx = 1'b0;
    hold_ticks(3);
    check("glitch_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    hold_ticks(16);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_no_valid", 32'(valid_rises), 32'(rises0));

    // Bad stop bit, then a good frame
    exp_q.push_back(expect_word(8'h3C, 1'b0, good_par(8'h3C)));
    send_frame(8'h3C, 1'b0, good_par(8'h3C));
    hold_ticks(16);
    check("fe_flag", 32'(frame_err), 32'd1);
    exp_q.push_back(expect_word(8'h3D, 1'b1, good_par(8'h3D)));
    send_frame(8'h3D, 1'b1, good_par(8'h3D));
    hold_ticks(4);
    check("fe_clear", 32'(frame_err), 32'd0);
    check("fe_drained", 32'(exp_q.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
    exp_q.push_back(expect_word(8'h07, 1'b1, 1'b1));
    send_frame(8'h07, 1'b1, 1'b1);
    hold_ticks(4);
    check("par_ok", 32'(parity_err), 32'(P_ODD));
    exp_q.push_back(expect_word(8'h07, 1'b1, 1'b0));
    send_frame(8'h07, 1'b1, 1'b0);
    hold_ticks(4);
    check("par_bad", 32'(parity_err), 32'(!P_ODD));
`endif

    // Overrun: two frames back to back with no consumer
    ready_mode = 0;
    hold_ticks(2);
    ovr0 = ovr_cycles;
    send_frame(8'h11, 1'b1, good_par(8'h11));
    send_frame(8'h22, 1'b1, good_par(8'h22));
    hold_ticks(4);
    check("ovr_pulse", 32'(ovr_cycles - ovr0), 32'd1);
    check("ovr_data", 32'(rx_data), 32'h22);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    exp_q.push_back(expect_word(8'h22, 1'b1, good_par(8'h22)));
    ready_mode = 1;
    hold_ticks(2);
    check("ovr_drained", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 4 of 0xFF, then 0x5A
    rises0 = valid_rises;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    hold_ticks(8);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    rst_n = 1'b1;
    hold_ticks(16);
    exp_q.push_back(expect_word(8'h5A, 1'b1, good_par(8'h5A)));
    send_frame(8'h5A, 1'b1, good_par(8'h5A));
    hold_ticks(4);
    check("rst_only_5a", 32'(valid_rises - rises0), 32'd1);
    check("rst_drained", 32'(exp_q.size()), 32'd0);

    // Randomized frames, stop errors, parity errors and glitches
    ready_mode = 2;
    ovr0 = ovr_cycles;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        rx = 1'b0;
        hold_ticks($urandom_range(1, 5));
        rx = 1'b1;
        hold_ticks(16);
      end
      d = DB'($urandom_range(0, (1 << DB) - 1));
      s = ($urandom_range(0, 7) != 0);
      p = good_par(d) ^ ($urandom_range(0, 5) == 0);
      exp_q.push_back(expect_word(d, s, p));
      send_frame(d, s, p);
      if (!s) hold_ticks(16);
      else    hold_ticks($urandom_range(0, 20));
    end
    for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("rand_drained", 32'(exp_q.size()), 32'd0);
    check("rand_no_overrun", 32'(ovr_cycles - ovr0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver that consumes the 16x-oversampling `rx_tick` strobe from the baud-rate generator and converts the asynchronous `rx` line into parallel bytes. It synchronises the line, detects and validates start bits, samples each bit at mid-bit, optionally checks parity, and presents each received word on a valid/ready handshake toward the APB register block, with frame, parity and overrun error flags.

## Interface
- `DATA_BITS`, 8, data bits per frame (5–9), LSB first
- `PARITY_ODD`, 0, parity sense when parity is compiled in: 0 = even, 1 = odd
- `clk` input 1, system clock
- `rst_n` input 1, asynchronous active-low reset
- `rx_tick` input 1, single-cycle pulse at 16x baud rate
- `rx` input 1, asynchronous serial line, idle high
- `rx_data` output DATA_BITS, last received word
- `rx_valid` output 1, `rx_data` holds an unread word
- `rx_ready` input 1, consumer accepts word when `rx_valid && rx_ready`
- `frame_err` output 1, stop bit of the word in `rx_data` sampled 0
- `parity_err` output 1, parity mismatch for the word in `rx_data` (tied 0 without parity)
- `overrun_err` output 1, one-cycle pulse when a word completes while `rx_valid` is still 1
- `busy` output 1, high in any state other than IDLE

## Operation
- `rx` passes through a 2-flop synchroniser, reset value 1; all logic uses the synchronised value.
- Tick counter: 4 bits, advances only on `rx_tick`, wraps 15→0; bit counter: $clog2(DATA_BITS) bits.
- States: IDLE, START, DATA, PARITY (only with parity compiled in), STOP.
- IDLE: on `rx_tick` with line 0 → START, tick counter cleared.
- START: at tick count 7 (mid start bit) line 0 → DATA, counters cleared; line 1 → IDLE (glitch rejected, no flags).
- DATA: every 16 ticks (count 15), sample line into shift register MSB end, shift right; after DATA_BITS samples → PARITY or STOP.
- PARITY: after 16 ticks, sample parity bit; error = XOR of data bits, parity bit, and PARITY_ODD, nonzero → error.
- STOP: after 16 ticks, sample stop bit; load `rx_data`, `frame_err` = !stop, `parity_err`; set `rx_valid`; → IDLE. Sampling is mid-bit, so the receiver re-arms half a bit early and tolerates a following start edge.
- Stop bit 0: word still delivered with `frame_err` = 1; no break detection.
- Handshake: `rx_valid` clears on the cycle after `rx_valid && rx_ready`; `rx_data` and error flags hold until next word completes.
- Completion while `rx_valid` = 1 and `rx_ready` = 0: new word overwrites `rx_data`/flags, `rx_valid` stays 1, `overrun_err` pulses one cycle.
- Completion in the same cycle as a handshake: new word loads, `rx_valid` stays 1, no overrun.
- Reset mid-frame: immediate return to IDLE, partial word discarded.

## Timing
- Reset values: `rx_data` 0, `rx_valid` 0, `frame_err` 0, `parity_err` 0, `overrun_err` 0, `busy` 0.
- Input latency: 2 clk synchroniser + up to one tick period of start detection.
- `rx_valid`, `rx_data`, flags update on the clk edge following the `rx_tick` that samples the stop bit (registered, 1 cycle).
- Frame length: (1 + DATA_BITS + parity + 1) × 16 ticks; `busy` falls with `rx_valid` rise.
- `rx_tick` held high for consecutive cycles counts once per cycle; no requirement to filter.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state present, one parity bit expected between data and stop, `parity_err` computed.
- Undefined: PARITY state and parity logic removed, STOP follows last data bit, `parity_err` tied 0, `PARITY_ODD` ignored.

## Structure
- Shared package `uart_pkg`: `uart_rx_state_t` enum, `UART_OVERSAMPLE` = 16, `UART_SAMPLE_MID` = 7; transmitter reuses the constants.
- Sub-module `uart_sync2`: 2-flop synchroniser with reset value parameter, reused for other async inputs.

## Test plan
- Frame 0xA5, 8N1, `rx_ready` held 1 → `rx_data` = 0xA5, `rx_valid` one cycle, all error flags 0.
- 3-tick low glitch on idle line → back to IDLE, `rx_valid` never rises, `busy` pulses only.
- 0x3C with stop bit 0 → `rx_data` = 0x3C, `frame_err` = 1; next frame 0x3D good → `frame_err` = 0.
- Parity compiled in, `PARITY_ODD` = 0: 0x07 with parity 1 → `parity_err` = 0; with parity 0 → `parity_err` = 1.
- `rx_ready` = 0, frames 0x11 then 0x22 back to back → `overrun_err` one-cycle pulse, `rx_data` = 0x22, `rx_valid` = 1.
- `rst_n` low during data bit 4 of 0xFF, released, then frame 0x5A → only 0x5A delivered, no flags.
